// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared change codes, coin values, dispenser states and change decode
package vend_pkg;

    localparam logic [2:0] CHANGE_0  = 3'd0;
    localparam logic [2:0] CHANGE_5  = 3'd1;
    localparam logic [2:0] CHANGE_10 = 3'd2;
    localparam logic [2:0] CHANGE_15 = 3'd3;
    localparam logic [2:0] CHANGE_20 = 3'd4;

    localparam int NICKEL_CENTS  = 5;
    localparam int DIME_CENTS    = 10;
    localparam int QUARTER_CENTS = 25;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPENSE = 3'd1,
        EJECT    = 3'd2,
        GAP      = 3'd3,
        FAULT    = 3'd4
    } state_e;

    // Codes above CHANGE_20 are malformed; they still dispense but pay no change.
    function automatic logic [2:0] change_to_nickels(input logic [2:0] code);
        return (code <= CHANGE_20) ? code : 3'd0;
    endfunction

    function automatic logic change_is_bad(input logic [2:0] code);
        return code > CHANGE_20;
    endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// rtl/vend_dispenser_if.sv - controller/hopper side signals of the dispenser
interface vend_dispenser_if;
    logic       soda_i;
    logic [2:0] change_i;
    logic       coin_done_i;
    logic       motor_o;
    logic       eject_o;
    logic       busy_o;
    logic       overflow_o;
    logic       fault_o;

    modport master (
        output soda_i, change_i, coin_done_i,
        input  motor_o, eject_o, busy_o, overflow_o, fault_o
    );

    modport slave (
        input  soda_i, change_i, coin_done_i,
        output motor_o, eject_o, busy_o, overflow_o, fault_o
    );
endinterface

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable down-counter; done marks the final counted cycle
module vend_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - runs the soda motor then pays change one nickel at a time
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    vend_dispenser_if.slave  bus
);

    localparam int MW = $clog2(MOTOR_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e     state, state_n;
    logic [2:0] nick_cnt, nick_n;
    logic       pend_valid, pend_valid_n;
    logic [2:0] pend_code, pend_code_n;
    logic       overflow, overflow_n;
    logic       fault, fault_n;

    logic       mot_load, mot_done, to_load, to_done;
    logic       finish, start, req_taken;
    logic [2:0] start_code;

    vend_timer #(.WIDTH(MW)) u_motor_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (mot_load),
        .load_val (MW'(MOTOR_CYCLES)),
        .en       (state == DISPENSE),
        .done     (mot_done)
    );

    vend_timer #(.WIDTH(TW)) u_eject_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (to_load),
        .load_val (TW'(TIMEOUT_CYCLES)),
        .en       (state == EJECT),
        .done     (to_done)
    );

    always_comb begin
        state_n      = state;
        nick_n       = nick_cnt;
        pend_valid_n = pend_valid;
        pend_code_n  = pend_code;
        overflow_n   = overflow;
        fault_n      = fault;
        mot_load     = 1'b0;
        to_load      = 1'b0;
        finish       = 1'b0;
        start        = 1'b0;
        req_taken    = 1'b0;
        start_code   = bus.change_i;

        case (state)
            IDLE: begin
                if (bus.soda_i) begin
                    start     = 1'b1;
                    req_taken = 1'b1;
                end
            end
            DISPENSE: begin
                if (mot_done) begin
                    if (nick_cnt != 3'd0) begin
                        state_n = EJECT;
                        to_load = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            EJECT: begin
                // An ack on the very last timeout cycle still counts as a good coin.
                if (bus.coin_done_i) begin
                    nick_n = nick_cnt - 3'd1;
                    if (nick_cnt > 3'd1) state_n = GAP;
                    else                 finish  = 1'b1;
                end else if (to_done) begin
                    state_n = FAULT;
                    fault_n = 1'b1;
                end
            end
            GAP: begin
                state_n = EJECT;
                to_load = 1'b1;
            end
            FAULT:   fault_n = 1'b1;
            default: state_n = IDLE;
        endcase

        // Chain straight into the next vend so back-to-back requests see no idle bubble.
        if (finish) begin
            if (pend_valid) begin
                start        = 1'b1;
                start_code   = pend_code;
                pend_valid_n = 1'b0;
            end else if (bus.soda_i) begin
                start     = 1'b1;
                req_taken = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end

        if (start) begin
            state_n  = DISPENSE;
            mot_load = 1'b1;
            nick_n   = change_to_nickels(start_code);
            if (change_is_bad(start_code)) fault_n = 1'b1;
        end

        if (bus.soda_i && !req_taken) begin
            if (state != FAULT && !pend_valid_n) begin
                pend_valid_n = 1'b1;
                pend_code_n  = bus.change_i;
            end else begin
                overflow_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            nick_cnt   <= 3'd0;
            pend_valid <= 1'b0;
            pend_code  <= 3'd0;
            overflow   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_n;
            nick_cnt   <= nick_n;
            pend_valid <= pend_valid_n;
            pend_code  <= pend_code_n;
            overflow   <= overflow_n;
            fault      <= fault_n;
        end
    end

    assign bus.motor_o    = (state == DISPENSE);
    assign bus.eject_o    = (state == EJECT);
    assign bus.busy_o     = (state != IDLE) || pend_valid;
    assign bus.overflow_o = overflow;
    assign bus.fault_o    = fault;

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - directed self-checking bench for vend_dispenser
module tb_vend_dispenser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    vend_dispenser_if bus ();

    vend_dispenser #(.MOTOR_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_motor"},    int'(bus.motor_o),    0);
        check({tag, "_eject"},    int'(bus.eject_o),    0);
        check({tag, "_busy"},     int'(bus.busy_o),     0);
        check({tag, "_overflow"}, int'(bus.overflow_o), 0);
        check({tag, "_fault"},    int'(bus.fault_o),    0);
    endtask

    task automatic pulse_soda(input logic [2:0] code);
        bus.soda_i   = 1'b1;
        bus.change_i = code;
        @(negedge clk);
        bus.soda_i   = 1'b0;
        bus.change_i = 3'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Hopper acks on the second high cycle of each eject; runs until busy drops.
    task automatic run_hopper(input string tag, output int pulses, output int busy_cyc,
                              output int motor_cyc, output int bad_gap);
        int  high_run = 0;
        int  low_run  = 0;
        int  n        = 0;
        logic prev    = 1'b0;
        bit  finished = 1'b0;
        pulses = 0; busy_cyc = 0; motor_cyc = 0; bad_gap = 0;
        while (!finished && n < 300) begin
            if (!bus.busy_o) begin
                finished = 1'b1;
            end else begin
                busy_cyc++;
                if (bus.motor_o) begin
                    motor_cyc++;
                    low_run = 0;
                end
                if (bus.eject_o) begin
                    if (!prev) begin
                        pulses++;
                        if (low_run != 0 && low_run != 1) bad_gap++;
                    end
                    high_run++;
                    low_run = 0;
                    bus.coin_done_i = (high_run == 2);
                end else begin
                    bus.coin_done_i = 1'b0;
                    high_run = 0;
                    if (!bus.motor_o) low_run++;
                end
                prev = bus.eject_o;
                @(negedge clk);
                n++;
            end
        end
        bus.coin_done_i = 1'b0;
        check({tag, "_completed"}, int'(finished), 1);
    endtask

    initial begin
        int pulses, busy_cyc, motor_cyc, bad_gap, ec, n;
        bus.soda_i      = 1'b0;
        bus.change_i    = 3'd0;
        bus.coin_done_i = 1'b0;

        #1;
        outs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single vend, no change
        pulse_soda(3'd0);
        check("v0_motor_first", int'(bus.motor_o), 1);
        check("v0_busy_first",  int'(bus.busy_o),  1);
        ec = 0;
        repeat (7) begin
            if (bus.eject_o) ec++;
            @(negedge clk);
        end
        check("v0_motor_last", int'(bus.motor_o), 1);
        @(negedge clk);
        check("v0_motor_end", int'(bus.motor_o), 0);
        check("v0_busy_end",  int'(bus.busy_o),  0);
        check("v0_no_eject",  ec, 0);

        // Four nickels: 8 motor + 4*2 eject + 3 gaps
        pulse_soda(3'd4);
        run_hopper("v4", pulses, busy_cyc, motor_cyc, bad_gap);
        check("v4_pulses",   pulses,    4);
        check("v4_busy_cyc", busy_cyc,  19);
        check("v4_motor",    motor_cyc, 8);
        check("v4_gap",      bad_gap,   0);
        check("v4_fault",    int'(bus.fault_o), 0);

        // Pending request chained, third request dropped
        pulse_soda(3'd1);
        @(negedge clk);
        pulse_soda(3'd2);
        check("pend_no_ovf", int'(bus.overflow_o), 0);
        pulse_soda(3'd3);
        check("pend_ovf", int'(bus.overflow_o), 1);
        run_hopper("pend", pulses, busy_cyc, motor_cyc, bad_gap);
        check("pend_pulses",   pulses,    3);
        check("pend_busy_cyc", busy_cyc,  20);
        check("pend_motor",    motor_cyc, 13);
        check("pend_gap",      bad_gap,   0);
        check("pend_ovf_sticky", int'(bus.overflow_o), 1);

        // Hopper timeout
        do_reset();
        outs_zero("rst2");
        pulse_soda(3'd2);
        ec = 0; n = 0;
        while (!bus.fault_o && n < 100) begin
            if (bus.eject_o) ec++;
            @(negedge clk);
            n++;
        end
        check("to_reached",  int'(bus.fault_o), 1);
        check("to_eject_hi", ec, 16);
        check("to_motor",    int'(bus.motor_o), 0);
        check("to_eject",    int'(bus.eject_o), 0);
        check("to_busy",     int'(bus.busy_o),  1);
        pulse_soda(3'd1);
        check("to_drop_ovf", int'(bus.overflow_o), 1);
        repeat (3) @(negedge clk);
        check("to_stuck_motor", int'(bus.motor_o), 0);
        check("to_stuck_busy",  int'(bus.busy_o),  1);
        do_reset();
        outs_zero("rst3");

        // Bad change code still vends, then a good vend works
        pulse_soda(3'd6);
        run_hopper("bad", pulses, busy_cyc, motor_cyc, bad_gap);
        check("bad_pulses", pulses,    0);
        check("bad_motor",  motor_cyc, 8);
        check("bad_fault",  int'(bus.fault_o), 1);
        pulse_soda(3'd1);
        run_hopper("after", pulses, busy_cyc, motor_cyc, bad_gap);
        check("after_pulses",   pulses,   1);
        check("after_busy_cyc", busy_cyc, 10);

        // Asynchronous reset mid-eject with a request pending
        do_reset();
        pulse_soda(3'd3);
        pulse_soda(3'd2);
        n = 0;
        while (!bus.eject_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_in_eject", int'(bus.eject_o), 1);
        #2;
        rst = 1'b1;
        #1;
        outs_zero("async");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy",  int'(bus.busy_o),  0);
        check("post_rst_motor", int'(bus.motor_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
